round_sequencer: RTL and testbench

Match-level controller that sits between the top-level stage FSM and the fight datapath. It sequences a best-of-N fight as a series of rounds: pre-round countdown, timed fight, KO hold and score update. It issues per-round reset pulses to the health/position logic and reports a final match win or lose for the stage FSM to consume. It runs on the frame clock, so one cycle is one frame.

---
 rtl/fight_pkg.sv | 19 +
 rtl/round_sequencer_sec_timer.sv | 50 +++++
 rtl/round_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_round_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared types for the fight match controller: round state encoding and
// round-winner codes used on Round_Winner.
package fight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ROUND_INIT = 3'd1,
    ST_COUNTDOWN  = 3'd2,
    ST_FIGHT      = 3'd3,
    ST_ROUND_OVER = 3'd4,
    ST_MATCH_OVER = 3'd5
  } round_state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_NPC    = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

endpackage

// File: rtl/round_sequencer_sec_timer.sv
// Seconds timer: frame down-counter nested under a seconds down-counter.
// A load of N runs for exactly N*FPS cycles; loading 0 parks the timer.
module sec_timer #(
  parameter int FPS = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [6:0] load_secs_i,
  output logic [6:0] sec_o,
  output logic       expire_o
);

  localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;
  localparam logic [FW-1:0] FRAME_TOP = FW'(FPS - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic [6:0]    sec_q, sec_d;

  // Expiry is the edge on which the last frame of the last second ends.
  assign expire_o = (sec_q == 7'd1) && (frame_q == '0);
  assign sec_o    = sec_q;

  always_comb begin
    sec_d   = sec_q;
    frame_d = frame_q;
    if (load_i) begin
      sec_d   = load_secs_i;
      frame_d = FRAME_TOP;
    end else if (sec_q != 7'd0) begin
      if (frame_q == '0) begin
        sec_d   = sec_q - 7'd1;
        frame_d = (sec_q == 7'd1) ? '0 : FRAME_TOP;
      end else begin
        frame_d = frame_q - FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sec_q   <= '0;
      frame_q <= '0;
    end else begin
      sec_q   <= sec_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Best-of-N match controller: countdown, fight, KO hold and score update per round.
// Define ROUND_SEQUENCER_TIMEOUT_EN to end FIGHT on the round timer as well as on a KO.
module round_sequencer
  import fight_pkg::*;
#(
  parameter int FPS            = 60,
  parameter int COUNTDOWN_SECS = 3,
  parameter int ROUND_SECS     = 60,
  parameter int KO_HOLD_FRAMES = 120,
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int MAX_ROUNDS     = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_match_i,
  input  logic       abort_i,
  input  logic       player_dead_i,
  input  logic       npc_dead_i,
  input  logic [7:0] player_hp_i,
  input  logic [7:0] npc_hp_i,
  input  logic       match_ack_i,
  output logic       fight_active_o,
  output logic       round_reset_o,
  output logic [2:0] round_num_o,
  output logic [1:0] player_wins_o,
  output logic [1:0] npc_wins_o,
  output logic [1:0] round_winner_o,
  output logic [6:0] sec_left_o,
  output logic       match_win_o,
  output logic       match_lose_o
);

  localparam int HW = (KO_HOLD_FRAMES > 1) ? $clog2(KO_HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(KO_HOLD_FRAMES - 1);
  localparam logic [1:0]    WINS_NEEDED = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0]    ROUND_CAP   = 3'(MAX_ROUNDS);
  localparam logic [6:0]    CD_LOAD     = 7'(COUNTDOWN_SECS);
  localparam logic [6:0]    RS_LOAD     = 7'(ROUND_SECS);

  round_state_t  state_q, state_d;
  logic [2:0]    round_num_q, round_num_d;
  logic [1:0]    player_wins_q, player_wins_d;
  logic [1:0]    npc_wins_q, npc_wins_d;
  logic [1:0]    winner_q, winner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          match_win_q, match_win_d;
  logic          match_lose_q, match_lose_d;
  logic          fight_active_q, round_reset_q;
  logic [1:0]    outcome;

  logic          tmr_load;
  logic [6:0]    tmr_secs;
  logic [6:0]    tmr_sec;
  logic          tmr_expire;
  logic          show_sec;

  sec_timer #(.FPS(FPS)) u_sec_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (tmr_load),
    .load_secs_i (tmr_secs),
    .sec_o       (tmr_sec),
    .expire_o    (tmr_expire)
  );

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  assign show_sec = (state_q == ST_COUNTDOWN) || (state_q == ST_FIGHT);
`else
  logic unused_hp;
  assign unused_hp = ^{player_hp_i, npc_hp_i};
  assign show_sec  = (state_q == ST_COUNTDOWN);
`endif

  always_comb begin
    state_d       = state_q;
    round_num_d   = round_num_q;
    player_wins_d = player_wins_q;
    npc_wins_d    = npc_wins_q;
    winner_d      = winner_q;
    hold_d        = hold_q;
    match_win_d   = match_win_q;
    match_lose_d  = match_lose_q;
    outcome       = WIN_NONE;
    tmr_load      = 1'b0;
    tmr_secs      = RS_LOAD;

    unique case (state_q)
      ST_IDLE: begin
        if (start_match_i) begin
          player_wins_d = '0;
          npc_wins_d    = '0;
          round_num_d   = 3'd1;
          state_d       = ST_ROUND_INIT;
        end
      end
      ST_ROUND_INIT: begin
        tmr_load = 1'b1;
        tmr_secs = CD_LOAD;
        state_d  = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (tmr_expire) begin
          state_d = ST_FIGHT;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
          tmr_load = 1'b1;
`endif
        end
      end
      ST_FIGHT: begin
        // KO checks come first so a KO on the expiry frame beats the timeout.
        if (player_dead_i && npc_dead_i) outcome = WIN_DRAW;
        else if (npc_dead_i)             outcome = WIN_PLAYER;
        else if (player_dead_i)          outcome = WIN_NPC;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
        else if (tmr_expire) begin
          if (player_hp_i > npc_hp_i)      outcome = WIN_PLAYER;
          else if (player_hp_i < npc_hp_i) outcome = WIN_NPC;
          else                             outcome = WIN_DRAW;
        end
`endif
        if (outcome != WIN_NONE) begin
          winner_d = outcome;
          if (outcome == WIN_PLAYER) player_wins_d = player_wins_q + 2'd1;
          if (outcome == WIN_NPC)    npc_wins_d    = npc_wins_q + 2'd1;
          hold_d  = HOLD_LOAD;
          state_d = ST_ROUND_OVER;
        end
      end
      ST_ROUND_OVER: begin
        if (hold_q == '0) begin
          winner_d = WIN_NONE;
          if ((player_wins_q == WINS_NEEDED) || (npc_wins_q == WINS_NEEDED) ||
              (round_num_q == ROUND_CAP)) begin
            match_win_d  = (player_wins_q > npc_wins_q);
            match_lose_d = !(player_wins_q > npc_wins_q);
            state_d      = ST_MATCH_OVER;
          end else begin
            round_num_d = round_num_q + 3'd1;
            state_d     = ST_ROUND_INIT;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      ST_MATCH_OVER: begin
        if (match_ack_i) begin
          round_num_d   = '0;
          player_wins_d = '0;
          npc_wins_d    = '0;
          match_win_d   = 1'b0;
          match_lose_d  = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort parks the timer by loading zero seconds.
    if (abort_i) begin
      state_d       = ST_IDLE;
      round_num_d   = '0;
      player_wins_d = '0;
      npc_wins_d    = '0;
      winner_d      = WIN_NONE;
      hold_d        = '0;
      match_win_d   = 1'b0;
      match_lose_d  = 1'b0;
      tmr_load      = 1'b1;
      tmr_secs      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      round_num_q    <= '0;
      player_wins_q  <= '0;
      npc_wins_q     <= '0;
      winner_q       <= WIN_NONE;
      hold_q         <= '0;
      match_win_q    <= 1'b0;
      match_lose_q   <= 1'b0;
      fight_active_q <= 1'b0;
      round_reset_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_num_q    <= round_num_d;
      player_wins_q  <= player_wins_d;
      npc_wins_q     <= npc_wins_d;
      winner_q       <= winner_d;
      hold_q         <= hold_d;
      match_win_q    <= match_win_d;
      match_lose_q   <= match_lose_d;
      fight_active_q <= (state_d == ST_FIGHT);
      round_reset_q  <= (state_d == ST_ROUND_INIT);
    end
  end

  assign fight_active_o = fight_active_q;
  assign round_reset_o  = round_reset_q;
  assign round_num_o    = round_num_q;
  assign player_wins_o  = player_wins_q;
  assign npc_wins_o     = npc_wins_q;
  assign round_winner_o = winner_q;
  assign sec_left_o     = show_sec ? tmr_sec : 7'd0;
  assign match_win_o    = match_win_q;
  assign match_lose_o   = match_lose_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: phase/remaining-cycle reference model compared every
// cycle, plus directed literal checks. Honours ROUND_SEQUENCER_TIMEOUT_EN.
module tb_round_sequencer;

  localparam int FPS  = 4;
  localparam int CD   = 2;
  localparam int RS   = 3;
  localparam int HOLD = 2;
  localparam int R2W  = 2;
  localparam int MAXR = 3;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, pdead = 1'b0, ndead = 1'b0, ack = 1'b0;
  logic [7:0] php = 8'd100, nhp = 8'd100;
  logic       fight_active, round_reset, match_win, match_lose;
  logic [2:0] round_num;
  logic [1:0] pwins, nwins, winner;
  logic [6:0] sec_left;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  round_sequencer #(
    .FPS(FPS), .COUNTDOWN_SECS(CD), .ROUND_SECS(RS), .KO_HOLD_FRAMES(HOLD),
    .ROUNDS_TO_WIN(R2W), .MAX_ROUNDS(MAXR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_match_i(start), .abort_i(abort),
    .player_dead_i(pdead), .npc_dead_i(ndead), .player_hp_i(php), .npc_hp_i(nhp),
    .match_ack_i(ack), .fight_active_o(fight_active), .round_reset_o(round_reset),
    .round_num_o(round_num), .player_wins_o(pwins), .npc_wins_o(nwins),
    .round_winner_o(winner), .sec_left_o(sec_left), .match_win_o(match_win),
    .match_lose_o(match_lose)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: phase plus cycles remaining in the current timed phase.
  localparam int M_IDLE = 0, M_INIT = 1, M_CD = 2, M_FIGHT = 3, M_RO = 4, M_MATCH = 5;
  int m_ph = M_IDLE, m_rem = 0, m_round = 0, m_pw = 0, m_nw = 0, m_winner = 0, m_w = 0;
  bit m_win = 1'b0, m_lose = 1'b0;

  task automatic m_clear();
    m_ph = M_IDLE; m_rem = 0; m_round = 0; m_pw = 0; m_nw = 0;
    m_winner = 0; m_win = 1'b0; m_lose = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || abort) m_clear();
    else begin
      case (m_ph)
        M_IDLE: if (start) begin m_ph = M_INIT; m_round = 1; m_pw = 0; m_nw = 0; end
        M_INIT: begin m_ph = M_CD; m_rem = CD * FPS; end
        M_CD: begin
          m_rem--;
          if (m_rem == 0) begin m_ph = M_FIGHT; m_rem = TO_EN ? RS * FPS : 0; end
        end
        M_FIGHT: begin
          m_w = 0;
          if (pdead && ndead) m_w = 3;
          else if (ndead) m_w = 1;
          else if (pdead) m_w = 2;
          else if (TO_EN && m_rem == 1) m_w = (php > nhp) ? 1 : (php < nhp) ? 2 : 3;
          if (TO_EN) m_rem--;
          if (m_w != 0) begin
            m_winner = m_w;
            if (m_w == 1) m_pw++;
            if (m_w == 2) m_nw++;
            m_ph = M_RO; m_rem = HOLD;
          end
        end
        M_RO: begin
          m_rem--;
          if (m_rem == 0) begin
            m_winner = 0;
            if (m_pw == R2W || m_nw == R2W || m_round == MAXR) begin
              m_ph = M_MATCH; m_win = (m_pw > m_nw); m_lose = !(m_pw > m_nw);
            end else begin
              m_round++; m_ph = M_INIT;
            end
          end
        end
        M_MATCH: if (ack) m_clear();
        default: m_clear();
      endcase
    end
  end

  function automatic int m_sec();
    if (m_ph == M_CD || (m_ph == M_FIGHT && TO_EN)) return (m_rem + FPS - 1) / FPS;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("fight_active", fight_active, m_ph == M_FIGHT);
      chk("round_reset", round_reset, m_ph == M_INIT);
      chk("round_num", round_num, m_round);
      chk("player_wins", pwins, m_pw);
      chk("npc_wins", nwins, m_nw);
      chk("round_winner", winner, m_winner);
      chk("sec_left", sec_left, m_sec());
      chk("match_win", match_win, m_win);
      chk("match_lose", match_lose, m_lose);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_match();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fight();
    int n = 0;
    while (!fight_active && n < 40) begin @(negedge clk); n++; end
    chk("wait_fight", fight_active, 1);
  endtask

  task automatic ko_round(input logic pd, input logic nd);
    wait_fight();
    pdead = pd; ndead = nd;
    @(negedge clk);
    pdead = 1'b0; ndead = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    int n;
    tick(2);
    chk("reset_round_num", round_num, 0);
    chk("reset_fight_active", fight_active, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // Start-up timing and player sweep
    start_match();
    chk("lit_round_reset", round_reset, 1);
    chk("lit_round_num1", round_num, 1);
    tick(1);
    chk("lit_sec2", sec_left, 2);
    chk("lit_round_reset_low", round_reset, 0);
    tick(4);
    chk("lit_sec1", sec_left, 1);
    tick(3);
    chk("lit_fight_not_yet", fight_active, 0);
    tick(1);
    chk("lit_fight_rise", fight_active, 1);
    ndead = 1'b1;
    tick(2);
    ndead = 1'b0;
    chk("lit_winner_player", winner, 1);
    chk("lit_pwins1", pwins, 1);
    tick(1);
    chk("lit_round2_reset", round_reset, 1);
    chk("lit_round_num2", round_num, 2);
    ko_round(1'b0, 1'b1);
    chk("lit_pwins2", pwins, 2);
    tick(2);
    tick(3);
    chk("lit_match_win", match_win, 1);
    chk("lit_match_lose0", match_lose, 0);
    do_ack();
    chk("lit_ack_round_num", round_num, 0);
    chk("lit_ack_pwins", pwins, 0);
    chk("lit_ack_win", match_win, 0);
    tick(2);

    // Timeout (or KO-only fight) then draws up to the round cap
    php = 8'd40; nhp = 8'd50;
    start_match();
    wait_fight();
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
    chk("lit_fight_sec3", sec_left, 3);
    n = 0;
    while (fight_active && n < 40) begin n++; @(negedge clk); end
    chk("lit_fight_len", n, 12);
    chk("lit_timeout_winner", winner, 2);
    chk("lit_timeout_nwins", nwins, 1);
    tick(2);
    php = 8'd50;
    wait_fight();
    n = 0;
    while (fight_active && n < 40) begin n++; @(negedge clk); end
    chk("lit_equal_hp_winner", winner, 3);
    chk("lit_equal_hp_nwins", nwins, 1);
    tick(2);
`else
    tick(100);
    chk("lit_no_timeout_fight", fight_active, 1);
    chk("lit_no_timeout_sec", sec_left, 0);
    ko_round(1'b1, 1'b0);
    chk("lit_npc_winner", winner, 2);
    chk("lit_ko_nwins", nwins, 1);
    tick(2);
    ko_round(1'b1, 1'b1);
    chk("lit_double_ko_winner", winner, 3);
    chk("lit_double_ko_nwins", nwins, 1);
    tick(2);
`endif
    ko_round(1'b1, 1'b1);
    chk("lit_cap_round_num", round_num, 3);
    tick(2);
    chk("lit_cap_lose", match_lose, 1);
    chk("lit_cap_round_num_hold", round_num, 3);
    do_ack();
    php = 8'd100; nhp = 8'd100;

    // Three straight draws
    start_match();
    ko_round(1'b1, 1'b1); tick(2);
    ko_round(1'b1, 1'b1); tick(2);
    ko_round(1'b1, 1'b1);
    chk("lit_draws_round3", round_num, 3);
    tick(2);
    chk("lit_draws_lose", match_lose, 1);
    chk("lit_draws_pwins", pwins, 0);
    do_ack();

    // Abort mid-FIGHT with a tally already scored
    start_match();
    ko_round(1'b0, 1'b1);
    tick(2);
    wait_fight();
    tick(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("lit_abort_fight", fight_active, 0);
    chk("lit_abort_pwins", pwins, 0);
    chk("lit_abort_round_num", round_num, 0);
    tick(2);

    // Asynchronous reset mid-COUNTDOWN
    start_match();
    tick(3);
    chk("lit_pre_reset_sec", sec_left, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_sec", sec_left, 0);
    chk("lit_async_round_num", round_num, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    chk("lit_post_reset_idle", round_num, 0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
